// File: rtl/fft_cbfp_shift_apply.sv
// Block-floating-point shift stage: buffers FFT beats until their block leading-zero
// count arrives, then normalizes every lane and emits the matching block exponent.
module fft_cbfp_shift_apply #(
  parameter int ARRAY_SIZE = 16,
  parameter int DIN_W      = 23,
  parameter int DOUT_W     = 11,
  parameter int CNT_W      = 5,
  parameter int BUF_DEPTH  = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           valid_in,
  input  logic [ARRAY_SIZE*DIN_W-1:0]    din_re,
  input  logic [ARRAY_SIZE*DIN_W-1:0]    din_im,
  input  logic                           cnt_valid,
  input  logic [CNT_W-1:0]               cnt_in,
  output logic                           valid_out,
  output logic [ARRAY_SIZE*DOUT_W-1:0]   dout_re,
  output logic [ARRAY_SIZE*DOUT_W-1:0]   dout_im,
  output logic signed [CNT_W:0]          exp_out,
  output logic                           err_ovf,
  output logic                           err_unf
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int OCC_W = $clog2(BUF_DEPTH + 1);
  localparam int SHR   = DIN_W - DOUT_W;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(BUF_DEPTH - 1);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(BUF_DEPTH);

  logic [ARRAY_SIZE*DIN_W-1:0] mem_re_r [BUF_DEPTH];
  logic [ARRAY_SIZE*DIN_W-1:0] mem_im_r [BUF_DEPTH];
  logic [PTR_W-1:0]            wr_ptr_r;
  logic [PTR_W-1:0]            rd_ptr_r;
  logic [OCC_W-1:0]            occ_r;

  logic                         empty_s, full_s, bypass_s, pop_s, push_s, ovf_s, unf_s, fire_s;
  logic [ARRAY_SIZE*DIN_W-1:0]  sel_re_s, sel_im_s;
  logic [ARRAY_SIZE*DOUT_W-1:0] nxt_re_s, nxt_im_s;
  logic [CNT_W-1:0]             sh_s;
  logic signed [CNT_W:0]        exp_s;

  // Left shift drops redundant sign bits; the top DOUT_W bits are the floor-truncated result.
  function automatic logic [DOUT_W-1:0] shift_lane(input logic [DIN_W-1:0] d,
                                                   input logic [CNT_W-1:0] s);
    logic [DIN_W-1:0] t;
    t = d << s;
    return t[DIN_W-1 -: DOUT_W];
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_LAST) begin
      return PTR_W'(0);
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  // Buffer control decode and per-lane normalization of the selected beat
  always_comb begin
    empty_s  = (occ_r == OCC_W'(0));
    full_s   = (occ_r == OCC_FULL);
    bypass_s = cnt_valid & valid_in & empty_s;
    pop_s    = cnt_valid & ~empty_s;
    unf_s    = cnt_valid & empty_s & ~valid_in;
    push_s   = valid_in & ~bypass_s & (~full_s | pop_s);
    ovf_s    = valid_in & full_s & ~pop_s;
    fire_s   = pop_s | bypass_s;
    if (bypass_s) begin
      sel_re_s = din_re;
      sel_im_s = din_im;
    end else begin
      sel_re_s = mem_re_r[rd_ptr_r];
      sel_im_s = mem_im_r[rd_ptr_r];
    end
    // Counts beyond the sample width would shift the sign bit out entirely
    if (int'(cnt_in) > DIN_W - 1) begin
      sh_s = CNT_W'(DIN_W - 1);
    end else begin
      sh_s = cnt_in;
    end
    exp_s    = (CNT_W+1)'(SHR) - (CNT_W+1)'(sh_s);
    nxt_re_s = {(ARRAY_SIZE*DOUT_W){1'b0}};
    nxt_im_s = {(ARRAY_SIZE*DOUT_W){1'b0}};
    for (int i = 0; i < ARRAY_SIZE; i++) begin
      nxt_re_s[i*DOUT_W +: DOUT_W] = shift_lane(sel_re_s[i*DIN_W +: DIN_W], sh_s);
      nxt_im_s[i*DOUT_W +: DOUT_W] = shift_lane(sel_im_s[i*DIN_W +: DIN_W], sh_s);
    end
  end

  // Beat storage; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_re_r[wr_ptr_r] <= din_re;
      mem_im_r[wr_ptr_r] <= din_im;
    end
  end

  // Pointers, occupancy and sticky error flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= PTR_W'(0);
      rd_ptr_r <= PTR_W'(0);
      occ_r    <= OCC_W'(0);
      err_ovf  <= 1'b0;
      err_unf  <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      case ({push_s, pop_s})
        2'b10:   occ_r <= occ_r + OCC_W'(1);
        2'b01:   occ_r <= occ_r - OCC_W'(1);
        default: occ_r <= occ_r;
      endcase
      err_ovf <= err_ovf | ovf_s;
      err_unf <= err_unf | unf_s;
    end
  end

  // Output register; data and exponent hold their last values between beats
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_out <= 1'b0;
      dout_re   <= {(ARRAY_SIZE*DOUT_W){1'b0}};
      dout_im   <= {(ARRAY_SIZE*DOUT_W){1'b0}};
      exp_out   <= (CNT_W+1)'(0);
    end else begin
      valid_out <= fire_s;
      if (fire_s) begin
        dout_re <= nxt_re_s;
        dout_im <= nxt_im_s;
        exp_out <= exp_s;
      end
    end
  end

endmodule

// File: tb/tb_fft_cbfp_shift_apply.sv
// Bench for fft_cbfp_shift_apply: constant vector table through the bypass path, then
// buffered sequences checked against a reference model through an output scoreboard.
module tb_fft_cbfp_shift_apply;
  localparam int N = 16, DW = 23, OW = 11, CW = 5, DEPTH = 4;
  localparam longint DIV = 64'd1 << (DW - OW);

  logic              clk = 1'b0;
  logic              rst;
  logic              valid_in, cnt_valid;
  logic [N*DW-1:0]   din_re, din_im;
  logic [CW-1:0]     cnt_in;
  logic              valid_out, err_ovf, err_unf;
  logic [N*OW-1:0]   dout_re, dout_im;
  logic signed [CW:0] exp_out;

  fft_cbfp_shift_apply #(.ARRAY_SIZE(N), .DIN_W(DW), .DOUT_W(OW), .CNT_W(CW), .BUF_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .din_re(din_re), .din_im(din_im),
    .cnt_valid(cnt_valid), .cnt_in(cnt_in), .valid_out(valid_out), .dout_re(dout_re),
    .dout_im(dout_im), .exp_out(exp_out), .err_ovf(err_ovf), .err_unf(err_unf));

  always #5 clk = ~clk;

  typedef struct { logic [N*OW-1:0] re; logic [N*OW-1:0] im; logic signed [CW:0] ex; } exp_t;
  typedef struct { logic [N*DW-1:0] re; logic [N*DW-1:0] im; } beat_t;
  typedef struct { logic [DW-1:0] re; logic [DW-1:0] im; int cnt;
                   logic [OW-1:0] ore; logic [OW-1:0] oim; logic signed [CW:0] oex; } vec_t;

  exp_t  sb[$];
  beat_t mq[$];
  exp_t  last_out;
  int    total = 0, bad = 0;
  bit    exp_ovf = 1'b0, exp_unf = 1'b0;
  vec_t  tbl[8];
  beat_t zb, b;

  task automatic chk_v(input string nm, input logic [191:0] a, input logic [191:0] r);
    total++;
    if (a !== r) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, a, r);
    end
  endtask

  // Two's-complement wrap to DW bits, then floor division: independent of the RTL bit slicing
  function automatic logic [OW-1:0] mdl_lane(input logic [DW-1:0] d, input int sh);
    longint v, o;
    v = longint'($signed(d)) * (longint'(1) << sh);
    v = v & ((longint'(1) << DW) - 1);
    if (v >= (longint'(1) << (DW - 1))) v = v - (longint'(1) << DW);
    if (v >= 0) o = v / DIV;
    else        o = -((-v + DIV - 1) / DIV);
    return o[OW-1:0];
  endfunction

  function automatic exp_t mdl(input beat_t bt, input int cnt);
    exp_t e;
    int sh;
    sh = (cnt > DW - 1) ? DW - 1 : cnt;
    for (int i = 0; i < N; i++) begin
      e.re[i*OW +: OW] = mdl_lane(bt.re[i*DW +: DW], sh);
      e.im[i*OW +: OW] = mdl_lane(bt.im[i*DW +: DW], sh);
    end
    e.ex = 6'((DW - OW) - sh);
    return e;
  endfunction

  function automatic beat_t rand_beat();
    beat_t r;
    logic signed [DW-1:0] v;
    for (int i = 0; i < N; i++) begin
      v = DW'($urandom); v = v >>> $urandom_range(0, DW - 1); r.re[i*DW +: DW] = v;
      v = DW'($urandom); v = v >>> $urandom_range(0, DW - 1); r.im[i*DW +: DW] = v;
    end
    return r;
  endfunction

  // Drive one cycle and advance the reference buffer model alongside it
  task automatic drive(input bit vi, input bit cv, input beat_t bt, input int cnt);
    bit popped, full;
    valid_in = vi; cnt_valid = cv; din_re = bt.re; din_im = bt.im; cnt_in = CW'(cnt);
    if (cv && vi && mq.size() == 0) begin
      sb.push_back(mdl(bt, cnt));
    end else begin
      popped = 1'b0;
      full = (mq.size() == DEPTH);
      if (cv) begin
        if (mq.size() > 0) begin
          sb.push_back(mdl(mq.pop_front(), cnt));
          popped = 1'b1;
        end else exp_unf = 1'b1;
      end
      if (vi) begin
        if (full && !popped) exp_ovf = 1'b1;
        else mq.push_back(bt);
      end
    end
    @(posedge clk); #1;
    valid_in = 1'b0; cnt_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 10 && sb.size() > 0; i++) begin
      @(negedge clk); #1;
    end
    chk_v("drain_pending", 192'(sb.size()), 192'(0));
  endtask

  task automatic chk_flags();
    chk_v("err_ovf", 192'(err_ovf), 192'(exp_ovf));
    chk_v("err_unf", 192'(err_unf), 192'(exp_unf));
  endtask

  task automatic chk_cleared();
    chk_v("rst_valid_out", 192'(valid_out), 192'(0));
    chk_v("rst_dout_re", 192'(dout_re), 192'(0));
    chk_v("rst_dout_im", 192'(dout_im), 192'(0));
    chk_v("rst_exp_out", 192'(exp_out), 192'(0));
    chk_v("rst_err_ovf", 192'(err_ovf), 192'(0));
    chk_v("rst_err_unf", 192'(err_unf), 192'(0));
  endtask

  // Output scoreboard: every valid_out must match the oldest expected result
  always @(negedge clk) begin
    if (!rst && valid_out) begin
      if (sb.size() == 0) begin
        chk_v("spurious_valid_out", 192'(valid_out), 192'(0));
      end else begin
        last_out = sb.pop_front();
        chk_v("dout_re", 192'(dout_re), 192'(last_out.re));
        chk_v("dout_im", 192'(dout_im), 192'(last_out.im));
        chk_v("exp_out", 192'(exp_out), 192'(last_out.ex));
      end
    end
  end

  initial begin
    tbl[0] = '{re: 23'sd256,      im: -23'sd256,  cnt: 13, ore: 11'sd512,   oim: -11'sd512,  oex: -6'sd1};
    tbl[1] = '{re: -23'sd1,       im: 23'sd0,     cnt: 30, ore: -11'sd1024, oim: 11'sd0,     oex: -6'sd10};
    tbl[2] = '{re: 23'h3FFFFF,    im: 23'h400000, cnt: 0,  ore: 11'sd1023,  oim: -11'sd1024, oex: 6'sd12};
    tbl[3] = '{re: -23'sd4096,    im: 23'sd4095,  cnt: 0,  ore: -11'sd1,    oim: 11'sd0,     oex: 6'sd12};
    tbl[4] = '{re: 23'sd100,      im: -23'sd100,  cnt: 5,  ore: 11'sd0,     oim: -11'sd1,    oex: 6'sd7};
    tbl[5] = '{re: 23'sd3,        im: -23'sd3,    cnt: 20, ore: 11'sd768,   oim: -11'sd768,  oex: -6'sd8};
    tbl[6] = '{re: 23'sd1,        im: 23'sd0,     cnt: 22, ore: -11'sd1024, oim: 11'sd0,     oex: -6'sd10};
    tbl[7] = '{re: 23'sd5,        im: 23'sd6,     cnt: 31, ore: -11'sd1024, oim: 11'sd0,     oex: -6'sd10};
    zb.re = '0; zb.im = '0;
    rst = 1'b1; valid_in = 1'b0; cnt_valid = 1'b0; din_re = '0; din_im = '0; cnt_in = '0;
    #12;
    chk_cleared();
    @(posedge clk); #1; rst = 1'b0;

    // Constant vectors through the empty-buffer bypass, every lane identical
    for (int i = 0; i < 8; i++) begin
      valid_in = 1'b1; cnt_valid = 1'b1; cnt_in = CW'(tbl[i].cnt);
      din_re = {N{tbl[i].re}}; din_im = {N{tbl[i].im}};
      sb.push_back('{re: {N{tbl[i].ore}}, im: {N{tbl[i].oim}}, ex: tbl[i].oex});
      @(posedge clk); #1;
      valid_in = 1'b0; cnt_valid = 1'b0;
      chk_v("bypass_occ", 192'(dut.occ_r), 192'(0));
    end
    wait_drain();
    chk_flags();

    // Buffered beat whose count arrives two cycles later
    b = rand_beat(); b.re[DW-1:0] = 23'sd256;
    drive(1, 0, b, 0); drive(0, 0, zb, 0); drive(0, 1, zb, 13);
    chk_v("late_cnt_valid", 192'(valid_out), 192'(1));
    chk_v("late_cnt_lane0", 192'(dout_re[OW-1:0]), 192'(11'sd512));
    chk_v("late_cnt_exp", 192'(exp_out), 192'(-6'sd1));
    wait_drain();

    // Full buffer with simultaneous push and pop keeps every beat
    for (int i = 0; i < DEPTH; i++) drive(1, 0, rand_beat(), 0);
    drive(1, 1, rand_beat(), $urandom_range(0, 31));
    for (int i = 0; i < DEPTH; i++) drive(0, 1, zb, $urandom_range(0, 31));
    wait_drain();
    chk_flags();
    chk_v("occ_after_full_pp", 192'(dut.occ_r), 192'(0));

    // Overflow on a fifth beat, then underflow on a fifth count
    for (int i = 0; i < DEPTH + 1; i++) drive(1, 0, rand_beat(), 0);
    chk_flags();
    for (int i = 0; i < DEPTH; i++) drive(0, 1, zb, $urandom_range(0, 31));
    drive(0, 1, zb, 7);
    chk_v("unf_no_valid", 192'(valid_out), 192'(0));
    wait_drain();
    chk_flags();
    repeat (3) @(posedge clk);
    #1;
    chk_v("hold_dout_re", 192'(dout_re), 192'(last_out.re));
    chk_v("hold_exp_out", 192'(exp_out), 192'(last_out.ex));

    // Random traffic mix
    for (int i = 0; i < 200; i++)
      drive($urandom_range(0, 1), ($urandom_range(0, 9) < 4), rand_beat(), $urandom_range(0, 31));
    wait_drain();
    chk_flags();

    // Reset with beats buffered discards them
    while (mq.size() > 0) drive(0, 1, zb, $urandom_range(0, 31));
    wait_drain();
    for (int i = 0; i < 3; i++) drive(1, 0, rand_beat(), 0);
    rst = 1'b1; #1;
    chk_cleared();
    mq.delete(); sb.delete(); exp_ovf = 1'b0; exp_unf = 1'b0;
    @(posedge clk); #1; rst = 1'b0;
    drive(0, 1, zb, 9);
    chk_v("post_rst_no_valid", 192'(valid_out), 192'(0));
    chk_flags();
    drive(1, 0, rand_beat(), 0);
    drive(0, 1, zb, $urandom_range(0, 31));
    chk_v("post_rst_new_valid", 192'(valid_out), 192'(1));
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
